qsys_to_fifo: RTL
=================

QSYS_TO_FIFO -- requirements
Module: qsys_to_fifo

Interface
REQ-001 Parameters SHALL be, one per line:
 FIFO_SIZE, 256, depth in words (power of two, >= 4)
 FIFO_WIDTH, 16, data word width (1..32)
 CW derived as $clog2(FIFO_SIZE)+1, the fill-count width.
REQ-002 Ports SHALL be, one per line:
 avalon_clk  in  1  single clock for all logic
 avalon_reset_n  in  1  asynchronous, active-low reset
 avs_s0_write  in  1  Avalon-MM write strobe
 avs_s0_read  in  1  Avalon-MM read strobe
 avs_s0_address  in  2  register select
 avs_s0_writedata  in  32  write data
 avs_s0_readdata  out  32  registered read data
 avs_s0_interrupt  out  1  level interrupt to CPU
 fifo_rdreq  in  1  stream-side pop request
 fifo_q  out  FIFO_WIDTH  popped word
 fifo_empty  out  1  FIFO holds 0 words
 fifo_full  out  1  FIFO holds FIFO_SIZE words
 fifo_usedw  out  CW  current fill count
REQ-003 The block SHALL have one clock, avalon_clk; reset avalon_reset_n SHALL be asynchronous and active-low.

Function
REQ-004 Register map: addr 0 CTRL/STAT, addr 1 DATA (write-only push), addr 2 THRESH, addr 3 OVF.
REQ-005 Write addr 0: bit0 -> irq_en; bit1 = 1 flushes FIFO (pointers and count to 0) that cycle; bit1 not stored.
REQ-006 Read addr 0 SHALL return {zeros, fifo_usedw[CW-1:0], full, empty, irq_en} at bits [CW+2:3],[2],[1],[0].
REQ-007 Write addr 1 SHALL push writedata[FIFO_WIDTH-1:0] when not full; when full the word SHALL be dropped, FIFO unchanged.
REQ-008 Write addr 2 SHALL load THRESH from writedata[CW-1:0]; read addr 2 returns it zero-extended.
REQ-009 Read addr 1 SHALL return 0 and SHALL NOT pop.
REQ-010 avs_s0_readdata SHALL update on the clock edge where avs_s0_read is high (1-cycle latency) and hold otherwise; unmapped bits 0.
REQ-011 Pop: fifo_rdreq high and not empty SHALL advance read pointer; fifo_q SHALL present the popped word on the following cycle and hold until the next pop (non-show-ahead).
REQ-012 fifo_rdreq while empty SHALL be ignored; fifo_q and pointers unchanged.
REQ-013 Simultaneous accepted push and pop SHALL leave count unchanged; push is evaluated against pre-edge full (push while full rejected even with concurrent pop).
REQ-014 Flush SHALL win over a same-cycle push and pop: count 0 after the edge, fifo_q unchanged.
REQ-015 Pointers SHALL wrap modulo FIFO_SIZE; empty = (count==0), full = (count==FIFO_SIZE), both combinational from the registered count.
REQ-016 avs_s0_interrupt SHALL be registered: next value = irq_en AND (count <= THRESH), evaluated on post-edge values one cycle later.

Reset
REQ-017 On avalon_reset_n low, asynchronously: count, pointers, irq_en, THRESH, OVF = 0; avs_s0_readdata = 0; avs_s0_interrupt = 0; fifo_q = 0; fifo_empty = 1; fifo_full = 0.
REQ-018 Reset mid-operation SHALL discard all FIFO contents; storage RAM need not be cleared.

Configuration
REQ-019 Macro QSYS_TO_FIFO_OVF_EN defined: OVF bit0 SHALL set sticky on any dropped push (REQ-007); read addr 3 returns {31'b0, OVF}; write addr 3 with bit0=1 clears it (set wins on same cycle); interrupt term becomes irq_en AND ((count <= THRESH) OR OVF).
REQ-020 Macro undefined: no OVF register; read addr 3 returns 0; write addr 3 ignored; drops are silent.

Verification
REQ-021 Reset, then read addr 0 -> readdata = 0x2 (empty=1, irq_en=0); fifo_usedw = 0.
REQ-022 Push 0x1234, 0xABCD via addr 1, then pulse fifo_rdreq twice -> fifo_q = 0x1234 one cycle after first pop, 0xABCD after second; fifo_empty = 1.
REQ-023 Push 257 words into FIFO_SIZE=256 -> usedw = 256, full = 1, word 257 dropped; with QSYS_TO_FIFO_OVF_EN read addr 3 = 1, without = 0.
REQ-024 THRESH=2, irq_en=1, fill 4 words, pop 2 -> interrupt low at count 3, high one cycle after count reaches 2.
REQ-025 Full FIFO, same-cycle push and pop -> count 255, pushed word dropped; then flush with concurrent push -> count 0, empty = 1.
REQ-026 Assert avalon_reset_n low mid-stream with 10 words stored -> all outputs reach REQ-017 values without a clock edge.

Source files
------------

// File: rtl/qsys_to_fifo.sv
// qsys_to_fifo: Avalon-MM slave that pushes CPU writes into a FIFO drained by a stream-side pop port.
// Ports: avalon_clk/avalon_reset_n (async active-low); avs_s0_* Avalon-MM slave (addr 0 CTRL/STAT,
// 1 DATA push, 2 THRESH, 3 OVF) with 1-cycle registered readdata and level interrupt;
// fifo_rdreq/fifo_q/fifo_empty/fifo_full/fifo_usedw stream side (non-show-ahead).
// Optional macro QSYS_TO_FIFO_OVF_EN adds a sticky overflow flag at addr 3 feeding the interrupt.
module qsys_to_fifo #(
  parameter int FIFO_SIZE  = 256,
  parameter int FIFO_WIDTH = 16,
  localparam int CW = $clog2(FIFO_SIZE) + 1
) (
  input  logic                  avalon_clk,
  input  logic                  avalon_reset_n,
  input  logic                  avs_s0_write,
  input  logic                  avs_s0_read,
  input  logic [1:0]            avs_s0_address,
  input  logic [31:0]           avs_s0_writedata,
  output logic [31:0]           avs_s0_readdata,
  output logic                  avs_s0_interrupt,
  input  logic                  fifo_rdreq,
  output logic [FIFO_WIDTH-1:0] fifo_q,
  output logic                  fifo_empty,
  output logic                  fifo_full,
  output logic [CW-1:0]         fifo_usedw
);
  localparam int AW = CW - 1;
  logic [FIFO_WIDTH-1:0] mem_q [FIFO_SIZE];
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d, thresh_q, thresh_d;
  logic irq_en_q, irq_en_d, irq_q, irq_d, ovf_bit;
  logic [31:0] rdata_q, rdata_d;
  logic [FIFO_WIDTH-1:0] q_q, q_d;
  logic wr_ctrl, wr_data, wr_thr, flush, push, pop;
  assign wr_ctrl    = avs_s0_write && avs_s0_address == 2'd0;
  assign wr_data    = avs_s0_write && avs_s0_address == 2'd1;
  assign wr_thr     = avs_s0_write && avs_s0_address == 2'd2;
  assign fifo_empty = count_q == '0;
  assign fifo_full  = count_q == CW'(FIFO_SIZE);
  assign flush      = wr_ctrl && avs_s0_writedata[1];
  // Push is judged on the pre-edge full flag, so a concurrent pop never frees room for it.
  assign push       = wr_data && !fifo_full;
  assign pop        = fifo_rdreq && !fifo_empty;
`ifdef QSYS_TO_FIFO_OVF_EN
  logic ovf_q, ovf_d;
  assign ovf_bit = ovf_q;
  // A drop in the same cycle as a clear leaves the flag set.
  assign ovf_d   = (wr_data && fifo_full) ||
                   (ovf_q && !(avs_s0_write && avs_s0_address == 2'd3 && avs_s0_writedata[0]));
  always_ff @(posedge avalon_clk or negedge avalon_reset_n)
    if (!avalon_reset_n) ovf_q <= 1'b0;
    else ovf_q <= ovf_d;
`else
  assign ovf_bit = 1'b0;
`endif
  always_comb begin
    count_d  = flush ? '0 : count_q + CW'(push) - CW'(pop);
    wptr_d   = flush ? '0 : wptr_q + AW'(push);
    rptr_d   = flush ? '0 : rptr_q + AW'(pop);
    q_d      = (pop && !flush) ? mem_q[rptr_q] : q_q;
    irq_en_d = wr_ctrl ? avs_s0_writedata[0] : irq_en_q;
    thresh_d = wr_thr ? avs_s0_writedata[CW-1:0] : thresh_q;
    irq_d    = irq_en_q && (count_q <= thresh_q || ovf_bit);
    rdata_d  = !avs_s0_read ? rdata_q :
               avs_s0_address == 2'd0 ? 32'({count_q, fifo_full, fifo_empty, irq_en_q}) :
               avs_s0_address == 2'd2 ? 32'(thresh_q) :
               avs_s0_address == 2'd3 ? {31'b0, ovf_bit} : 32'b0;
  end
  always_ff @(posedge avalon_clk)
    if (push) mem_q[wptr_q] <= avs_s0_writedata[FIFO_WIDTH-1:0];
  always_ff @(posedge avalon_clk or negedge avalon_reset_n)
    if (!avalon_reset_n) begin
      count_q  <= '0;
      wptr_q   <= '0;
      rptr_q   <= '0;
      q_q      <= '0;
      irq_en_q <= 1'b0;
      thresh_q <= '0;
      irq_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      count_q  <= count_d;
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      q_q      <= q_d;
      irq_en_q <= irq_en_d;
      thresh_q <= thresh_d;
      irq_q    <= irq_d;
      rdata_q  <= rdata_d;
    end
  assign avs_s0_readdata  = rdata_q;
  assign avs_s0_interrupt = irq_q;
  assign fifo_q           = q_q;
  assign fifo_usedw       = count_q;
endmodule
